// File: rtl/branch_target_cache_pkg.sv
// Shared definitions for the branch target cache: 2-bit counter encodings and table defaults.
// Counter MSB set means "predict taken".
package branch_target_cache_pkg;

    localparam int DEF_INDEX_BITS = 3;
    localparam int DEF_STAT_WIDTH = 16;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

    localparam cnt_t CNT_ALLOC = CNT_WT;
    localparam cnt_t CNT_RESET = CNT_WNT;

    function automatic logic predicts_taken(input cnt_t cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/branch_target_cache_counter.sv
// 2-bit saturating predictor counter next-state: +1 on taken, -1 on not-taken, clamped at ends.
// Purely combinational, zero latency, no flow control.
module branch_target_cache_counter
    import branch_target_cache_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] next_cnt_o
);

    always_comb begin
        next_cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_ST) begin
                next_cnt_o = cnt_i + 2'd1;
            end
        end else if (cnt_i != CNT_SNT) begin
            next_cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_cache.sv
// Direct-mapped branch target cache: zero-latency lookup on fetch_pc, trained by branch resolution.
// All state moves on negedge clock alongside the PC register; no backpressure, every update is absorbed.
module branch_target_cache
    import branch_target_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           fetch_pc,
    output logic                  do_bcache,
    output logic [31:0]           bcache_pc,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic                  update_taken,
    input  logic [31:0]           update_target,
    input  logic                  update_predicted,
    input  logic                  invalidate_all,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] stat_hits,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    cnt_t               cnt_q    [ENTRIES];
    cnt_t               cnt_d    [ENTRIES];

    logic [STAT_WIDTH-1:0] hits_q, hits_d;
    logic [STAT_WIDTH-1:0] misp_q, misp_d;

    logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0]      fetch_tag, upd_tag;
    logic                  fetch_hit, upd_hit, upd_en;
    cnt_t                  upd_cnt_next;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], update_pc[1:0]};

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = fetch_pc[31:INDEX_BITS+2];
    assign upd_idx   = update_pc[INDEX_BITS+1:2];
    assign upd_tag   = update_pc[31:INDEX_BITS+2];

    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_en    = enable && update_valid;

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign do_bcache  = fetch_hit && predicts_taken(cnt_q[fetch_idx]) && reset;
    assign bcache_pc  = do_bcache ? target_q[fetch_idx] : 32'd0;
    assign mispredict = update_valid && (update_predicted != update_taken);

    assign stat_hits        = hits_q;
    assign stat_mispredicts = misp_q;

    branch_target_cache_counter u_upd_counter (
        .cnt_i      (cnt_q[upd_idx]),
        .taken_i    (update_taken),
        .next_cnt_o (upd_cnt_next)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (invalidate_all) begin
            valid_d = '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                cnt_d[upd_idx] = upd_cnt_next;
                if (update_taken) begin
                    target_d[upd_idx] = update_target;
                end
            end else if (update_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = update_target;
                cnt_d[upd_idx]    = CNT_ALLOC;
            end
        end
    end

    // Statistics still count an update that invalidate_all dropped from the table.
    always_comb begin
        hits_d = hits_q;
        misp_d = misp_q;
        if (upd_en) begin
            if (update_predicted == update_taken) begin
                hits_d = hits_q + STAT_WIDTH'(1);
            end else begin
                misp_d = misp_q + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(negedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            hits_q  <= '0;
            misp_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_RESET;
            end
        end else begin
            valid_q <= valid_d;
            hits_q  <= hits_d;
            misp_q  <= misp_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule
